// File: rtl/pulse_pkg.sv
// pulse_pkg: shared FSM encoding, default widths and pulse-width trigger mode codes
package pulse_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int NUM_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pulse_state_t;

    // func_sel codes of the pulse-width trigger that this generator exercises
    typedef enum logic [1:0] {
        FUNC_GT = 2'b00,
        FUNC_LT = 2'b01,
        FUNC_IN = 2'b10
    } func_sel_t;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter with terminal-count flag, reloaded once per pulse phase
//   cnt_clk  : counter clock
//   cnt_clr  : asynchronous active-low reset
//   load     : load load_val this cycle
//   load_val : value to count down from
//   tc       : counter is at zero
module phase_timer import pulse_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             cnt_clk,
    input  logic             cnt_clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge cnt_clk or negedge cnt_clr) begin
        if (!cnt_clr) cnt <= '0;
        else          cnt <= load ? load_val : (cnt == '0 ? cnt : cnt - 1'b1);
    end

    assign tc = cnt == '0;

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: programmable pulse-train generator with exact high/low widths in cnt_clk cycles
//   cnt_clk, cnt_clr      : clock, asynchronous active-low reset
//   start, stop           : burst request / abort (stop wins)
//   high_width, low_width : active / inactive phase lengths (0 behaves as 1)
//   pulse_num             : pulses per burst, 0 = continuous
//   polarity              : 0 = active-high, 1 = active-low
//   pulse_out, busy, done : registered pulse, burst-in-progress, completion strobe
//   pulse_cnt             : pulses fully emitted in current/last burst (saturating)
module pulse_gen import pulse_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             cnt_clk,
    input  logic             cnt_clr,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] high_width,
    input  logic [CNT_W-1:0] low_width,
    input  logic [NUM_W-1:0] pulse_num,
    input  logic             polarity,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);

    pulse_state_t     state, state_nxt;
    logic [CNT_W-1:0] hw_l, lw_l, load_val;
    logic [NUM_W-1:0] num_l, cnt_inc;
    logic             pol_l, pol_sel, load, tc, accept, pulse_end, fin;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .cnt_clk  (cnt_clk),
        .cnt_clr  (cnt_clr),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    assign cnt_inc = &pulse_cnt ? pulse_cnt : pulse_cnt + 1'b1;
    // idle level follows the live polarity; during and at the end of a burst the latched one
    assign pol_sel = state == IDLE ? polarity : pol_l;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_val  = '0;
        accept    = 1'b0;
        pulse_end = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: if (start && !stop) begin
                // the start cycle itself is spent in HIGH with the output still inactive,
                // so the first HIGH phase counts H+1 cycles (H down to 0)
                accept    = 1'b1;
                state_nxt = HIGH;
                load      = 1'b1;
                load_val  = high_width == '0 ? CNT_W'(1) : high_width;
            end
            HIGH: if (stop) state_nxt = IDLE;
            else if (tc) begin
                state_nxt = LOW;
                load      = 1'b1;
                load_val  = lw_l == '0 ? '0 : lw_l - 1'b1;
            end
            LOW: if (stop) state_nxt = IDLE;
            else if (tc) begin
                pulse_end = 1'b1;
                if (num_l != '0 && cnt_inc == num_l) begin
                    state_nxt = IDLE;
                    fin       = 1'b1;
                end else begin
                    state_nxt = HIGH;
                    load      = 1'b1;
                    load_val  = hw_l == '0 ? '0 : hw_l - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cnt_clk or negedge cnt_clr) begin
        if (!cnt_clr) begin
            state     <= IDLE;
            hw_l      <= '0;
            lw_l      <= '0;
            num_l     <= '0;
            pol_l     <= 1'b0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hw_l  <= high_width;
                lw_l  <= low_width;
                num_l <= pulse_num;
                pol_l <= polarity;
            end
            pulse_out <= (state != IDLE && state_nxt == HIGH) ? ~pol_sel : pol_sel;
            busy      <= state_nxt != IDLE;
            done      <= fin;
            pulse_cnt <= accept ? '0 : (pulse_end ? cnt_inc : pulse_cnt);
        end
    end

endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Programmable pulse-train generator; the transmit-side counterpart of the pulse-width trigger detector.
- Emits pulses of exact, register-programmed high and low widths, counted in cnt_clk cycles.
- Drives the self-test/calibration path, so the pulse-width trigger (greater-than, less-than and inside-window modes) can be exercised against known widths.
- Sits beside the trigger logic in the cnt_clk domain. Configuration comes from host registers.

Parameters:
- CNT_W, 32: width of the high/low width counters and width inputs.
- NUM_W, 16: width of the pulse-count input and the emitted-count output.

Ports:
- cnt_clk  input  1  counter clock; single clock domain.
- cnt_clr  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a burst; sampled on rising edge.
- stop  input  1  abort request; sampled on rising edge.
- high_width  input  CNT_W  active-phase length in cycles.
- low_width  input  CNT_W  inactive-phase length in cycles.
- pulse_num  input  NUM_W  pulses per burst; 0 = continuous.
- polarity  input  1  0 = active-high pulses, 1 = active-low pulses.
- pulse_out  output  1  registered pulse output.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle strobe at normal burst completion.
- pulse_cnt  output  NUM_W  pulses fully emitted in current/last burst.

Behaviour:
- Reset (cnt_clr=0, asynchronous): state IDLE; busy=0, done=0, pulse_cnt=0. pulse_out equals the inactive level (~polarity applied combinationally is not allowed; the registered reset value is 0, and the inactive level is taken from polarity on the first clock after release).
- Reset mid-burst aborts immediately. No done is produced.
- States: IDLE, HIGH, LOW.
- IDLE:
  - pulse_out = inactive level (polarity).
  - start=1 at edge k: latch high_width, low_width, pulse_num and polarity; clear pulse_cnt; set busy; enter HIGH.
- Pulse timing:
  - pulse_out is active from edge k+1 for exactly H cycles.
  - It is then inactive for exactly L cycles.
  - The cycle pattern repeats.
  - H = max(high_width_latched, 1) and L = max(low_width_latched, 1). A width of 0 is treated as 1.
- HIGH: down-counter loaded with H-1 counts to 0, then the state moves to LOW.
- LOW:
  - Down-counter loaded with L-1.
  - At the end of LOW, pulse_cnt increments (saturating at all-ones).
  - If pulse_num_latched != 0 and the incremented count equals pulse_num_latched: go to IDLE, clear busy, assert done for one cycle on that same edge.
  - Otherwise return to HIGH.
- Continuous mode (pulse_num=0): runs until stop. pulse_cnt saturates; it does not wrap.
- stop=1 in HIGH or LOW:
  - Next edge: IDLE, pulse_out inactive, busy=0, no done.
  - pulse_cnt holds the number of completed pulses; a truncated pulse is not counted.
- stop and start asserted in the same cycle: stop wins, state stays/becomes IDLE.
- start while busy: ignored. Inputs changing while busy have no effect until the next start.
- done and start in the same cycle: start is accepted the cycle after done (IDLE required).
- Counter arithmetic is unsigned CNT_W bits. Maximum width is 2^CNT_W-1 cycles, with no overflow.
- Outputs are all registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package (pulse_pkg): FSM state encoding (IDLE=2'd0, HIGH=2'd1, LOW=2'd2) and the CNT_W/NUM_W defaults. The pulse-width trigger's func_sel codes (00 greater, 01 less, 10 inside) also go there, so benches can reuse them.
- One natural sub-module: phase_timer (loadable CNT_W down-counter with a terminal-count flag), instantiated once and reloaded per phase.

Test Plan:
- high_width=3, low_width=2, pulse_num=2, polarity=0, start at edge 10:
  - pulse_out=1 during cycles 11-13, 0 during 14-15, 1 during 16-18, 0 during 19-20.
  - done=1 at edge 21 only; busy 1 during 10-20; pulse_cnt=2.
- polarity=1, high_width=0, low_width=0, pulse_num=3: pulse_out toggles 0/1 each cycle, three low cycles total; pulse_cnt=3; done strobe once.
- pulse_num=0, high_width=5, low_width=5; stop asserted mid-HIGH of 4th pulse: pulse_out inactive the next edge, busy=0, done never asserted, pulse_cnt=3.
- Second start during burst with different widths: ignored; waveform matches the first configuration exactly.
- cnt_clr driven low mid-LOW (asynchronous, between edges): busy, done and pulse_cnt go to 0 immediately. After release, pulse_out idles at the inactive level until the next start.
- Loopback into the pulse-width trigger with cmp_low=50, cmp_high=150:
  - high_width=100 → inside-mode status 1.
  - high_width=200 → greater-mode status 1.
  - high_width=20 → less-mode status 1.
